mobo_bus_responder: RTL and testbench
=====================================

Name: mobo_bus_responder

Overview:
- Motherboard-side responder for the cpu bus (mobo_ctrl / mobo_stat / addr / data).
- Takes one request at a time from the cpu and serves it from an internal word RAM, or forwards it as a one-cycle write strobe to the VGA framebuffer port.
- Drives the status and read-data lines back to the cpu using a four-phase req/ack handshake with programmable wait states.

Parameters:
- word_width, 32, width of the addr, data, ctrl and stat words.
- RAM_WORDS, 256, internal RAM depth; RAM occupies word addresses 0..RAM_WORDS-1.
- VGA_BASE, 32'h1000, first word address of the VGA write window.
- VGA_WORDS, 2048, size of the VGA window in words.
- WAIT_CYCLES, 2, BUSY cycles inserted before commit; 0 is legal.
- COUNT_ADDR, 32'h2000, address of the transaction counter (used only with the optional feature).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- mobo_ctrl  in  word_width  bit0 = req, bit1 = we (1 write, 0 read); other bits ignored.
- mobo_stat  out  word_width  bit0 = ack, bit1 = busy, bit2 = err; other bits 0.
- addr  in  word_width  cpu word address.
- data_in  in  word_width  write data from the cpu (its data_out).
- data_out  out  word_width  read data to the cpu (its data_in).
- vga_we  out  1  one-cycle VGA write strobe.
- vga_addr  out  word_width  addr - VGA_BASE; valid when vga_we = 1.
- vga_data  out  word_width  write data; valid when vga_we = 1.

Behaviour:
- Reset: state = IDLE; mobo_stat, data_out, vga_we, vga_addr and vga_data are all 0. RAM contents are not cleared.
- FSM states are IDLE, BUSY and DONE; all outputs are registered.
- IDLE:
  - On posedge with req = 1: latch addr, we and data_in; load the wait counter with WAIT_CYCLES.
  - Go to BUSY if WAIT_CYCLES > 0, else go directly to DONE with commit.
  - busy = 1 from the next cycle while in BUSY.
- BUSY:
  - Counter decrements each cycle.
  - On the cycle it reaches 0: commit, then go to DONE.
  - Result: ack rises exactly WAIT_CYCLES + 1 cycles after req is sampled.
- Commit (entry to DONE), decided by the latched address:
  - RAM hit, write: RAM[a] <= data.
  - RAM hit, read: data_out <= RAM[a].
  - VGA hit, write: vga_we = 1 for exactly one cycle with vga_addr and vga_data.
  - VGA hit, read: data_out = 0, err = 0 (window is write-only).
  - Unmapped address: err = 1, data_out = 0, no side effect.
- DONE:
  - ack = 1, busy = 0; err and data_out are held stable.
  - When req is sampled 0: go to IDLE; ack, err and data_out clear the next cycle.
- req dropped during BUSY: the transaction still completes. ack is shown for at least one cycle, then IDLE.
- req still high in DONE: no new transaction. The next request needs req low for at least one sample (ack low) first.
- Changes to addr, we or data_in after the latch cycle are ignored until the next IDLE sample.
- rst during BUSY: the transaction is aborted and no write occurs. rst on the commit edge takes priority, so no write occurs.
- Address compare is full word_width, unsigned. VGA hit means VGA_BASE <= a < VGA_BASE + VGA_WORDS.
- Regions are checked in priority order RAM, VGA, counter.

Optional Feature:
- MOBO_XACT_COUNT_EN defined:
  - A word_width counter increments on every commit (including err commits) and wraps to 0 after all-ones.
  - Read at COUNT_ADDR returns the value before this transaction's increment.
  - Write at COUNT_ADDR sets the counter to 0; that write does not itself count.
  - rst clears the counter.
- Not defined: no counter logic; COUNT_ADDR is treated as unmapped (err = 1).

Test Plan:
- WAIT_CYCLES = 2, write 32'hDEAD_BEEF to addr 5, then read addr 5 → ack rises 3 cycles after req is sampled; read data_out = 32'hDEAD_BEEF, err = 0; busy high for exactly 2 cycles.
- Write 32'h0000_0041 to addr 32'h1003 → vga_we high for exactly one cycle with vga_addr = 3, vga_data = 32'h41. A read from 32'h1003 returns 0 with err = 0.
- Read from addr 32'h0000_0500 (unmapped) → err = 1, data_out = 0; the RAM word at (0x500 mod 256) = 0 is unchanged.
- WAIT_CYCLES = 0 variant; hold req high for 4 cycles after ack → ack rises 1 cycle after req and stays high until req drops. No second transaction occurs (vga_we/RAM write count = 1).
- Assert rst on the cycle before commit of a write of 32'h1234 to addr 7 → RAM[7] keeps its prior value; mobo_stat = 0 and state = IDLE next cycle.
- With MOBO_XACT_COUNT_EN: 3 RAM writes, then read COUNT_ADDR → returns 3; write COUNT_ADDR, then read → returns 0. Without the macro, the read of COUNT_ADDR gives err = 1.

Source files
------------

// File: rtl/mobo_bus_if.sv
// CPU-side bus bundle between the cpu and the motherboard responder.
interface mobo_bus_if #(
  parameter int word_width = 32
);
  logic [word_width-1:0] mobo_ctrl;
  logic [word_width-1:0] mobo_stat;
  logic [word_width-1:0] addr;
  logic [word_width-1:0] data_in;
  logic [word_width-1:0] data_out;

  modport master (output mobo_ctrl, addr, data_in, input mobo_stat, data_out);
  modport slave  (input mobo_ctrl, addr, data_in, output mobo_stat, data_out);
endinterface

// File: rtl/mobo_bus_responder.sv
// Motherboard responder: serves cpu requests from a word RAM or a write-only VGA window
// with a req/ack handshake. Optional transaction counter: define MOBO_XACT_COUNT_EN.
module mobo_bus_responder #(
  parameter int          word_width  = 32,
  parameter int          RAM_WORDS   = 256,
  parameter logic [31:0] VGA_BASE    = 32'h1000,
  parameter int          VGA_WORDS   = 2048,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] COUNT_ADDR  = 32'h2000
) (
  input  logic                  clk,
  input  logic                  rst,
  mobo_bus_if.slave             bus,
  output logic                  vga_we,
  output logic [word_width-1:0] vga_addr,
  output logic [word_width-1:0] vga_data
);

  localparam int                AW      = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [word_width:0] RAM_END = (word_width+1)'(RAM_WORDS);
  localparam logic [word_width:0] VGA_LO  = (word_width+1)'(VGA_BASE);
  localparam logic [word_width:0] VGA_HI  = VGA_LO + (word_width+1)'(VGA_WORDS);
  localparam logic [31:0]         WAIT_LD = 32'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state, state_nx;
  logic [31:0]           cnt, cnt_nx;
  logic [word_width-1:0] lat_addr, lat_data;
  logic                  lat_we;
  logic [word_width-1:0] ram [RAM_WORDS];

  logic                  req, ld, commit, ram_we;
  logic [word_width-1:0] x_addr, x_data;
  logic                  x_we;
  logic [word_width:0]   xa;
  logic                  ram_hit, vga_hit, cnt_hit;
  logic [AW-1:0]         ram_idx;
  logic [word_width-1:0] xcnt_val;

  logic                  ack, busy, err, ack_nx, busy_nx, err_nx;
  logic [word_width-1:0] dout, dout_nx;
  logic                  vga_we_nx;
  logic [word_width-1:0] vga_addr_nx, vga_data_nx;
  logic                  ctrl_unused;

  assign req         = bus.mobo_ctrl[0];
  assign ctrl_unused = ^bus.mobo_ctrl[word_width-1:2];

  // In IDLE the request is decoded straight off the bus so a zero-wait commit can use it.
  always_comb begin
    x_addr  = (state == IDLE) ? bus.addr         : lat_addr;
    x_data  = (state == IDLE) ? bus.data_in      : lat_data;
    x_we    = (state == IDLE) ? bus.mobo_ctrl[1] : lat_we;
    xa      = {1'b0, x_addr};
    ram_hit = xa < RAM_END;
    vga_hit = !ram_hit && (xa >= VGA_LO) && (xa < VGA_HI);
    ram_idx = x_addr[AW-1:0];
  end

`ifdef MOBO_XACT_COUNT_EN
  logic [word_width-1:0] xcnt;

  assign cnt_hit  = !ram_hit && !vga_hit && (x_addr == word_width'(COUNT_ADDR));
  assign xcnt_val = xcnt;

  // Every commit counts except the clearing write itself.
  always_ff @(posedge clk) begin
    if (rst)                    xcnt <= '0;
    else if (commit && cnt_hit && x_we) xcnt <= '0;
    else if (commit)            xcnt <= xcnt + 1'b1;
  end
`else
  assign cnt_hit  = 1'b0;
  assign xcnt_val = '0;
`endif

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    ld          = 1'b0;
    commit      = 1'b0;
    ram_we      = 1'b0;
    ack_nx      = ack;
    busy_nx     = busy;
    err_nx      = err;
    dout_nx     = dout;
    vga_we_nx   = 1'b0;
    vga_addr_nx = vga_addr;
    vga_data_nx = vga_data;
    case (state)
      IDLE: if (req) begin
        ld = 1'b1;
        if (WAIT_CYCLES > 0) begin
          state_nx = BUSY;
          cnt_nx   = WAIT_LD;
          busy_nx  = 1'b1;
        end else begin
          commit = 1'b1;
        end
      end
      BUSY: begin
        if (cnt == 32'd1) commit = 1'b1;
        else              cnt_nx = cnt - 32'd1;
      end
      DONE: if (!req) begin
        state_nx = IDLE;
        ack_nx   = 1'b0;
        err_nx   = 1'b0;
        dout_nx  = '0;
      end
      default: state_nx = IDLE;
    endcase

    if (commit) begin
      state_nx = DONE;
      ack_nx   = 1'b1;
      busy_nx  = 1'b0;
      err_nx   = 1'b0;
      dout_nx  = '0;
      if (ram_hit) begin
        if (x_we) ram_we  = 1'b1;
        else      dout_nx = ram[ram_idx];
      end else if (vga_hit) begin
        if (x_we) begin
          vga_we_nx   = 1'b1;
          vga_addr_nx = x_addr - VGA_LO[word_width-1:0];
          vga_data_nx = x_data;
        end
      end else if (cnt_hit) begin
        if (!x_we) dout_nx = xcnt_val;
      end else begin
        err_nx = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ack      <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      dout     <= '0;
      vga_we   <= 1'b0;
      vga_addr <= '0;
      vga_data <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      ack      <= ack_nx;
      busy     <= busy_nx;
      err      <= err_nx;
      dout     <= dout_nx;
      vga_we   <= vga_we_nx;
      vga_addr <= vga_addr_nx;
      vga_data <= vga_data_nx;
    end
  end

  // Request capture and RAM storage are data paths; reset only blocks the commit write.
  always_ff @(posedge clk) begin
    if (ld) begin
      lat_addr <= bus.addr;
      lat_data <= bus.data_in;
      lat_we   <= bus.mobo_ctrl[1];
    end
    if (!rst && ram_we) ram[ram_idx] <= x_data;
  end

  assign bus.mobo_stat = {{(word_width-3){1'b0}}, err, busy, ack};
  assign bus.data_out  = dout;

endmodule

// File: tb/tb_mobo_bus_responder.sv
// Randomized self-checking bench for mobo_bus_responder against a transaction-level model.
module tb_mobo_bus_responder;
  localparam int WAIT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mobo_bus_if #(.word_width(32)) cpu ();
  mobo_bus_if #(.word_width(32)) cpu0 ();
  logic        vga_we, vga_we0;
  logic [31:0] vga_addr, vga_data, vga_addr0, vga_data0;

  mobo_bus_responder #(.word_width(32), .WAIT_CYCLES(WAIT)) dut (
    .clk(clk), .rst(rst), .bus(cpu.slave),
    .vga_we(vga_we), .vga_addr(vga_addr), .vga_data(vga_data));

  mobo_bus_responder #(.word_width(32), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .bus(cpu0.slave),
    .vga_we(vga_we0), .vga_addr(vga_addr0), .vga_data(vga_data0));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: memory map semantics per transaction.
  logic [31:0] mem_m [256];
  bit          known [256];
  logic [31:0] xc_m = 0;

  function automatic void model(input bit w, input logic [31:0] a, input logic [31:0] d,
                                output logic [31:0] ed, output bit ee, output bit ev,
                                output bit cd);
    bit clr = 0;
    ed = 0; ee = 0; ev = 0; cd = 1;
    if (a < 256) begin
      if (w) begin mem_m[a] = d; known[a] = 1; end
      else begin ed = mem_m[a]; cd = known[a]; end
    end else if (a >= 32'h1000 && a < 32'h1000 + 2048) begin
      ev = w;
    end else if (a == 32'h2000) begin
`ifdef MOBO_XACT_COUNT_EN
      if (w) clr = 1; else ed = xc_m;
`else
      ee = 1;
`endif
    end else begin
      ee = 1;
    end
    xc_m = clr ? 32'd0 : xc_m + 1;
  endfunction

  task automatic xact(input bit w, input logic [31:0] a, input logic [31:0] d,
                      input bit early, output logic [31:0] rd, output bit got_err);
    logic [31:0] ed, va, vd, held;
    bit ee, ev, cd;
    int lat = 0, busy_n = 0, vga_n = 0, hold;
    model(w, a, d, ed, ee, ev, cd);
    rd = 0; got_err = 0; va = 0; vd = 0;
    @(negedge clk);
    cpu.mobo_ctrl = {$urandom(), w, 1'b1} & 32'hFFFF_FFFF;
    cpu.mobo_ctrl[1:0] = {w, 1'b1};
    cpu.addr = a; cpu.data_in = d;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (cpu.mobo_stat[1]) busy_n++;
      if (vga_we) begin vga_n++; va = vga_addr; vd = vga_data; end
      if (cpu.mobo_stat[0]) begin lat = k; rd = cpu.data_out; got_err = cpu.mobo_stat[2]; end
      cpu.addr = $urandom(); cpu.data_in = $urandom();
      cpu.mobo_ctrl[31:1] = 31'($urandom());
      if (early && k == 1) cpu.mobo_ctrl[0] = 1'b0;
    end
    if (lat == 0) begin
      chk("ack_timeout", 32'd0, 32'd1);
      cpu.mobo_ctrl = 0;
      return;
    end
    chk("ack_latency", lat, WAIT + 1);
    chk("busy_cycles", busy_n, WAIT);
    chk("err", {31'd0, got_err}, {31'd0, ee});
    chk("done_stat", cpu.mobo_stat, {29'd0, ee, 1'b0, 1'b1});
    if (!w && cd) chk("rdata", rd, ed);
    if (!w && ee) chk("err_rdata", rd, 32'd0);
    held = cpu.data_out;
    if (!early) begin
      hold = $urandom_range(0, 3);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (vga_we) vga_n++;
        chk("ack_hold", {31'd0, cpu.mobo_stat[0]}, 32'd1);
        chk("dout_hold", cpu.data_out, held);
      end
    end
    cpu.mobo_ctrl = 0;
    @(negedge clk);
    if (vga_we) vga_n++;
    chk("vga_pulses", vga_n, {31'd0, ev});
    if (ev) begin
      chk("vga_addr", va, a - 32'h1000);
      chk("vga_data", vd, d);
    end
    chk("idle_stat", cpu.mobo_stat, 32'd0);
    chk("idle_dout", cpu.data_out, 32'd0);
  endtask

  logic [31:0] edges [6] = '{32'h0000_00FF, 32'h0000_0100, 32'h0000_0FFF,
                             32'h0000_1000, 32'h0000_17FF, 32'h0000_1800};

  initial begin
    logic [31:0] rd, a, old7;
    bit e;
    int vga_n0;
    cpu.mobo_ctrl = 0; cpu.addr = 0; cpu.data_in = 0;
    cpu0.mobo_ctrl = 0; cpu0.addr = 0; cpu0.data_in = 0;
    repeat (3) @(negedge clk);
    chk("rst_stat", cpu.mobo_stat, 32'd0);
    chk("rst_dout", cpu.data_out, 32'd0);
    chk("rst_vga_we", {31'd0, vga_we}, 32'd0);
    chk("rst_vga_addr", vga_addr, 32'd0);
    chk("rst_vga_data", vga_data, 32'd0);
    chk("rst0_stat", cpu0.mobo_stat, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 256; i++) xact(1'b1, i, $urandom(), 1'b0, rd, e);

    xact(1'b1, 32'd5, 32'hDEAD_BEEF, 1'b0, rd, e);
    xact(1'b0, 32'd5, 32'h0, 1'b0, rd, e);
    chk("plan_read5", rd, 32'hDEAD_BEEF);
    xact(1'b1, 32'h1003, 32'h41, 1'b0, rd, e);
    xact(1'b0, 32'h1003, 32'h0, 1'b0, rd, e);
    chk("plan_vga_read", {rd[30:0], e}, 32'd0);
    xact(1'b0, 32'h500, 32'h0, 1'b0, rd, e);
    chk("plan_unmapped_err", {31'd0, e}, 32'd1);
    xact(1'b0, 32'h0, 32'h0, 1'b0, rd, e);

`ifdef MOBO_XACT_COUNT_EN
    xact(1'b1, 32'h2000, 32'h0, 1'b0, rd, e);
    for (int i = 0; i < 3; i++) xact(1'b1, 32'd20 + i, $urandom(), 1'b0, rd, e);
    xact(1'b0, 32'h2000, 32'h0, 1'b0, rd, e);
    chk("plan_count3", rd, 32'd3);
    xact(1'b1, 32'h2000, 32'h0, 1'b0, rd, e);
    xact(1'b0, 32'h2000, 32'h0, 1'b0, rd, e);
    chk("plan_count0", rd, 32'd0);
`else
    xact(1'b0, 32'h2000, 32'h0, 1'b0, rd, e);
    chk("plan_count_err", {31'd0, e}, 32'd1);
`endif

    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 7))
        0, 1, 2: a = $urandom_range(0, 255);
        3:       a = 32'h1000 + $urandom_range(0, 2047);
        4:       a = edges[$urandom_range(0, 5)];
        5:       a = 32'h2000;
        6:       a = $urandom();
        default: a = 32'hFFFF_FFFF;
      endcase
      xact(1'($urandom_range(0, 1)), a, $urandom(), $urandom_range(0, 3) == 0, rd, e);
    end

    // Reset in the middle of BUSY, then exactly on the commit edge.
    for (int pos = 1; pos <= 2; pos++) begin
      old7 = mem_m[7];
      @(negedge clk);
      cpu.mobo_ctrl = 32'd3; cpu.addr = 32'd7; cpu.data_in = 32'h1234;
      repeat (pos) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_stat", cpu.mobo_stat, 32'd0);
      chk("abort_vga_we", {31'd0, vga_we}, 32'd0);
      rst = 1'b0; cpu.mobo_ctrl = 0; xc_m = 0;
      xact(1'b0, 32'd7, 32'h0, 1'b0, rd, e);
      chk("abort_ram7", rd, old7);
    end

    // Zero-wait instance with req held after ack: exactly one VGA write.
    vga_n0 = 0;
    @(negedge clk);
    cpu0.mobo_ctrl = 32'd3; cpu0.addr = 32'h1005; cpu0.data_in = 32'h77;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (vga_we0) begin
        vga_n0++;
        chk("w0_vga_addr", vga_addr0, 32'd5);
        chk("w0_vga_data", vga_data0, 32'h77);
      end
      chk("w0_ack_held", {31'd0, cpu0.mobo_stat[0]}, 32'd1);
    end
    cpu0.mobo_ctrl = 0;
    @(negedge clk);
    if (vga_we0) vga_n0++;
    chk("w0_vga_count", vga_n0, 32'd1);
    chk("w0_idle_stat", cpu0.mobo_stat, 32'd0);
    cpu0.mobo_ctrl = 32'd3; cpu0.addr = 32'd9; cpu0.data_in = 32'hCAFE_0009;
    repeat (4) @(negedge clk);
    cpu0.mobo_ctrl = 0;
    @(negedge clk);
    cpu0.mobo_ctrl = 32'd1; cpu0.addr = 32'd9;
    @(negedge clk);
    chk("w0_read_ack", {31'd0, cpu0.mobo_stat[0]}, 32'd1);
    chk("w0_read9", cpu0.data_out, 32'hCAFE_0009);
    cpu0.mobo_ctrl = 0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
